speed_test_sequencer: RTL and testbench

// Next-generation speed-test control: a hardware-timed test sequencer with a simple register port, driven by the AXI-lite adapter.
// Per-port enable mask; ready-gated start; ms-resolution duration timer; abort; drain with timeout; atomic results snapshot; done irq.

---
 rtl/speed_test_sequencer.sv | 248 ++++++++++++++++++++++++
 tb/tb_speed_test_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/speed_test_sequencer.sv
// Hardware-timed speed-test sequencer: register port, per-port start/stop pulses,
// ms duration timer, abort, drain with timeout, results snapshot and done irq.
module speed_test_sequencer #(
  parameter int TEST_PORT_NUM = 4,
  parameter int CLOCK_FREQ    = 125000000,
  parameter int RESULT_WIDTH  = 128,
  parameter int CONFIG_WIDTH  = 256,
  parameter int READY_TIMEOUT = 1000000
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   reg_wr_en,
  input  logic [11:0]                            reg_wr_addr,
  input  logic [31:0]                            reg_wr_data,
  input  logic                                   reg_rd_en,
  input  logic [11:0]                            reg_rd_addr,
  output logic [31:0]                            reg_rd_data,
  output logic                                   reg_rd_valid,
  input  logic [TEST_PORT_NUM-1:0]               gen_ready,
  input  logic [TEST_PORT_NUM-1:0]               check_ready,
  input  logic [TEST_PORT_NUM*RESULT_WIDTH-1:0]  check_results,
  output logic [TEST_PORT_NUM-1:0]               start,
  output logic [TEST_PORT_NUM-1:0]               stop,
  output logic [TEST_PORT_NUM*CONFIG_WIDTH-1:0]  port_config,
  output logic                                   busy,
  output logic                                   irq
);
  // state      | meaning
  // IDLE       | waiting for go
  // WAIT_READY | waiting for masked generators/checkers ready (timeout)
  // START      | start pulse to masked ports, timer cleared
  // RUN        | ms timer counting towards DURATION_MS
  // STOP       | stop pulse to masked ports
  // DRAIN      | waiting for masked checkers to settle (timeout)
  // SNAP       | latch masked results into the snapshot
  // DONE       | done/irq held until clear_done or next go
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_WAIT_READY = 3'd1, S_START = 3'd2, S_RUN = 3'd3,
    S_STOP = 3'd4, S_DRAIN = 3'd5, S_SNAP = 3'd6, S_DONE = 3'd7
  } state_t;

  localparam int N         = TEST_PORT_NUM;
  localparam int CFG_WORDS = CONFIG_WIDTH / 32;
  localparam int RES_WORDS = RESULT_WIDTH / 32;
  localparam logic [31:0] TICK_LAST = 32'(CLOCK_FREQ / 1000 - 1);
  localparam logic [31:0] TO_LAST   = 32'(READY_TIMEOUT - 1);

  state_t                   state;
  logic                     busy_q, done_q, ready_to, drain_to, aborted_q;
  logic [N-1:0]             port_mask, mask_next;
  logic [31:0]              duration_ms, elapsed_ms, elapsed_inc, prescaler, to_cnt;
  logic [N*RESULT_WIDTH-1:0] snapshot;
  logic                     ctrl_wr, go, abort, clear_done, all_ready, drain_ready;
  logic                     wr_cfg, rd_cfg, rd_res;
  logic [3:0]               wr_cp, wr_cw, rd_cp, rd_cw;
  logic [7:0]               rd_rp;
  logic [1:0]               rd_rw;
  logic [31:0]              rd_word;

  // Config window 0x100..0x3FF (0x40 per port), result window from 0x400 (0x10 per port).
  always_comb begin
    wr_cp  = reg_wr_addr[9:6] - 4'd4;
    wr_cw  = reg_wr_addr[5:2];
    wr_cfg = (reg_wr_addr[1:0] == 2'b00) && (reg_wr_addr >= 12'h100) && (reg_wr_addr < 12'h400) &&
             (32'(wr_cp) < 32'(N)) && (32'(wr_cw) < 32'(CFG_WORDS));
    rd_cp  = reg_rd_addr[9:6] - 4'd4;
    rd_cw  = reg_rd_addr[5:2];
    rd_cfg = (reg_rd_addr[1:0] == 2'b00) && (reg_rd_addr >= 12'h100) && (reg_rd_addr < 12'h400) &&
             (32'(rd_cp) < 32'(N)) && (32'(rd_cw) < 32'(CFG_WORDS));
    rd_rp  = reg_rd_addr[11:4] - 8'h40;
    rd_rw  = reg_rd_addr[3:2];
    rd_res = (reg_rd_addr[1:0] == 2'b00) && (reg_rd_addr >= 12'h400) &&
             (32'(rd_rp) < 32'(N)) && (32'(rd_rw) < 32'(RES_WORDS));
  end

  assign ctrl_wr     = reg_wr_en && (reg_wr_addr == 12'h000);
  assign abort       = ctrl_wr && reg_wr_data[1];
  assign go          = ctrl_wr && reg_wr_data[0] && !reg_wr_data[1];
  assign clear_done  = ctrl_wr && reg_wr_data[2];
  assign mask_next   = (ctrl_wr && !busy_q) ? reg_wr_data[16 +: N] : port_mask;
  assign all_ready   = &((gen_ready & check_ready) | ~port_mask);
  assign drain_ready = &(check_ready | ~port_mask);
  assign elapsed_inc = (elapsed_ms == '1) ? elapsed_ms : elapsed_ms + 32'd1;
  assign busy        = busy_q;
  assign irq         = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      port_mask   <= '0;
      duration_ms <= '0;
      port_config <= '0;
    end else if (reg_wr_en && !busy_q) begin
      if (reg_wr_addr == 12'h000) port_mask <= reg_wr_data[16 +: N];
      if (reg_wr_addr == 12'h008) duration_ms <= reg_wr_data;
      for (int p = 0; p < N; p++)
        for (int w = 0; w < CFG_WORDS; w++)
          if (wr_cfg && 32'(wr_cp) == 32'(p) && 32'(wr_cw) == 32'(w))
            port_config[p*CONFIG_WIDTH + w*32 +: 32] <= reg_wr_data;
    end
  end

  always_comb begin
    rd_word = '0;
    if (reg_rd_addr == 12'h000) rd_word[16 +: N] = port_mask;
    if (reg_rd_addr == 12'h004) begin
      rd_word[0]    = busy_q;
      rd_word[1]    = done_q;
      rd_word[2]    = ready_to;
      rd_word[3]    = drain_to;
      rd_word[4]    = aborted_q;
      rd_word[10:8] = state;
    end
    if (reg_rd_addr == 12'h008) rd_word = duration_ms;
    if (reg_rd_addr == 12'h00C) rd_word = elapsed_ms;
    for (int p = 0; p < N; p++) begin
      for (int w = 0; w < CFG_WORDS; w++)
        if (rd_cfg && 32'(rd_cp) == 32'(p) && 32'(rd_cw) == 32'(w))
          rd_word = port_config[p*CONFIG_WIDTH + w*32 +: 32];
      for (int w = 0; w < RES_WORDS; w++)
        if (rd_res && 32'(rd_rp) == 32'(p) && 32'(rd_rw) == 32'(w))
          rd_word = snapshot[p*RESULT_WIDTH + w*32 +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_rd_data  <= '0;
      reg_rd_valid <= 1'b0;
    end else begin
      reg_rd_valid <= reg_rd_en;
      if (reg_rd_en) reg_rd_data <= rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ready_to    <= 1'b0;
      drain_to    <= 1'b0;
      aborted_q   <= 1'b0;
      start       <= '0;
      stop        <= '0;
      elapsed_ms  <= '0;
      prescaler   <= '0;
      to_cnt      <= '0;
      snapshot    <= '0;
    end else begin
      start <= '0;
      stop  <= '0;
      case (state)
        S_IDLE, S_DONE: begin
          if (clear_done) begin
            done_q <= 1'b0;
            state  <= S_IDLE;
          end
          if (go && mask_next != '0) begin
            state     <= S_WAIT_READY;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            ready_to  <= 1'b0;
            drain_to  <= 1'b0;
            aborted_q <= 1'b0;
            to_cnt    <= '0;
          end
        end
        S_WAIT_READY: begin
          if (abort) begin
            state     <= S_IDLE;
            busy_q    <= 1'b0;
            aborted_q <= 1'b1;
          end else if (all_ready) begin
            state      <= S_START;
            start      <= port_mask;
            elapsed_ms <= '0;
            prescaler  <= '0;
          end else if (to_cnt == TO_LAST) begin
            state    <= S_IDLE;
            busy_q   <= 1'b0;
            ready_to <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 32'd1;
          end
        end
        // The START cycle is the first cycle of the first ms, so stop lands
        // exactly DURATION_MS*tick cycles after start.
        S_START: begin
          if (prescaler == TICK_LAST) begin
            prescaler  <= '0;
            elapsed_ms <= elapsed_inc;
          end else begin
            prescaler <= prescaler + 32'd1;
          end
          if (abort) begin
            state     <= S_STOP;
            stop      <= port_mask;
            aborted_q <= 1'b1;
          end else begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            state     <= S_STOP;
            stop      <= port_mask;
            aborted_q <= 1'b1;
          end else if (elapsed_ms == duration_ms) begin
            state <= S_STOP;
            stop  <= port_mask;
          end else if (prescaler == TICK_LAST) begin
            prescaler  <= '0;
            elapsed_ms <= elapsed_inc;
            if (elapsed_inc == duration_ms) begin
              state <= S_STOP;
              stop  <= port_mask;
            end
          end else begin
            prescaler <= prescaler + 32'd1;
          end
        end
        S_STOP: begin
          state  <= S_DRAIN;
          to_cnt <= '0;
        end
        S_DRAIN: begin
          if (drain_ready) begin
            state <= S_SNAP;
          end else if (to_cnt == TO_LAST) begin
            state    <= S_SNAP;
            drain_to <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 32'd1;
          end
        end
        S_SNAP: begin
          for (int p = 0; p < N; p++)
            if (port_mask[p])
              snapshot[p*RESULT_WIDTH +: RESULT_WIDTH] <= check_results[p*RESULT_WIDTH +: RESULT_WIDTH];
          state  <= S_DONE;
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_speed_test_sequencer.sv
// Directed bench for speed_test_sequencer: register table vectors plus
// hand-written sequences for timing, timeout, abort and reset corners.
module tb_speed_test_sequencer;
  localparam int N  = 4;
  localparam int RW = 128;
  localparam int CW = 256;

  logic            clk = 1'b0;
  logic            rst;
  logic            reg_wr_en, reg_rd_en;
  logic [11:0]     reg_wr_addr, reg_rd_addr;
  logic [31:0]     reg_wr_data, reg_rd_data;
  logic            reg_rd_valid;
  logic [N-1:0]    gen_ready, check_ready, start, stop;
  logic [N*RW-1:0] check_results;
  logic [N*CW-1:0] port_config;
  logic            busy, irq;

  speed_test_sequencer #(
    .TEST_PORT_NUM(N), .CLOCK_FREQ(1000000), .RESULT_WIDTH(RW),
    .CONFIG_WIDTH(CW), .READY_TIMEOUT(50)
  ) dut (
    .clk(clk), .rst(rst),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr),
    .reg_rd_data(reg_rd_data), .reg_rd_valid(reg_rd_valid),
    .gen_ready(gen_ready), .check_ready(check_ready), .check_results(check_results),
    .start(start), .stop(stop), .port_config(port_config),
    .busy(busy), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [11:0] addr, input logic [31:0] data);
    reg_wr_en = 1'b1; reg_wr_addr = addr; reg_wr_data = data;
    tick();
    reg_wr_en = 1'b0;
  endtask

  task automatic reg_read_check(input string name, input logic [11:0] addr, input logic [31:0] exp);
    reg_rd_en = 1'b1; reg_rd_addr = addr;
    tick();
    reg_rd_en = 1'b0;
    check({name, "_valid"}, {31'b0, reg_rd_valid}, 32'd1);
    check(name, reg_rd_data, exp);
  endtask

  function automatic logic [31:0] res_word(input int p, input int w, input logic [31:0] salt);
    return (32'hA000_0000 | (32'(p) << 16) | 32'(w)) ^ salt;
  endfunction

  task automatic set_results(input logic [31:0] salt);
    for (int p = 0; p < N; p++)
      for (int w = 0; w < RW/32; w++)
        check_results[p*RW + w*32 +: 32] = res_word(p, w, salt);
  endtask

  task automatic wait_start();
    int c = 0;
    while (start == '0 && c < 20) begin tick(); c++; end
  endtask

  task automatic wait_stop(input int limit, output int c);
    c = 0;
    while (stop == '0 && c < limit) begin tick(); c++; end
  endtask

  task automatic wait_irq(input int limit, output int c);
    c = 0;
    while (!irq && c < limit) begin tick(); c++; end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic saw_start;
    rst = 1'b1; reg_wr_en = 1'b0; reg_rd_en = 1'b0;
    reg_wr_addr = '0; reg_wr_data = '0; reg_rd_addr = '0;
    gen_ready = '1; check_ready = '1;
    set_results(32'h0);
    repeat (3) tick();
    check("rst_start", {28'b0, start}, 32'd0);
    check("rst_stop", {28'b0, stop}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_cfg", {31'b0, |port_config}, 32'd0);
    rst = 1'b0;
    tick();

    vecs.push_back(vec_t'{1'b0, 12'h004, 32'h0, 32'h0});
    vecs.push_back(vec_t'{1'b0, 12'h000, 32'h0, 32'h0});
    vecs.push_back(vec_t'{1'b0, 12'h008, 32'h0, 32'h0});
    vecs.push_back(vec_t'{1'b1, 12'h008, 32'd3, 32'h0});
    vecs.push_back(vec_t'{1'b0, 12'h008, 32'h0, 32'd3});
    vecs.push_back(vec_t'{1'b1, 12'h000, 32'h0005_0000, 32'h0});
    vecs.push_back(vec_t'{1'b0, 12'h000, 32'h0, 32'h0005_0000});
    vecs.push_back(vec_t'{1'b1, 12'h100, 32'hDEAD_BEEF, 32'h0});
    vecs.push_back(vec_t'{1'b0, 12'h100, 32'h0, 32'hDEAD_BEEF});
    vecs.push_back(vec_t'{1'b1, 12'h1DC, 32'h1234_5678, 32'h0});
    vecs.push_back(vec_t'{1'b0, 12'h1DC, 32'h0, 32'h1234_5678});
    vecs.push_back(vec_t'{1'b1, 12'h120, 32'hFFFF_FFFF, 32'h0});
    vecs.push_back(vec_t'{1'b0, 12'h120, 32'h0, 32'h0});
    vecs.push_back(vec_t'{1'b1, 12'h200, 32'hFFFF_FFFF, 32'h0});
    vecs.push_back(vec_t'{1'b0, 12'h200, 32'h0, 32'h0});
    vecs.push_back(vec_t'{1'b1, 12'h00C, 32'd7, 32'h0});
    vecs.push_back(vec_t'{1'b0, 12'h00C, 32'h0, 32'h0});
    vecs.push_back(vec_t'{1'b0, 12'h010, 32'h0, 32'h0});
    vecs.push_back(vec_t'{1'b0, 12'h400, 32'h0, 32'h0});
    vecs.push_back(vec_t'{1'b0, 12'h440, 32'h0, 32'h0});
    vecs.push_back(vec_t'{1'b1, 12'h004, 32'hFFFF_FFFF, 32'h0});
    vecs.push_back(vec_t'{1'b0, 12'h004, 32'h0, 32'h0});
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) reg_write(vecs[i].addr, vecs[i].data);
      else reg_read_check($sformatf("vec%0d_rd_%03h", i, vecs[i].addr), vecs[i].addr, vecs[i].exp);
    end
    check("cfg_p0w0_port", port_config[31:0], 32'hDEAD_BEEF);
    check("cfg_p3w7_port", port_config[3*CW + 7*32 +: 32], 32'h1234_5678);
    check("cfg_p1w0_noalias", port_config[CW +: 32], 32'h0);

    // simultaneous read and write to one address returns the old value
    reg_wr_en = 1'b1; reg_wr_addr = 12'h008; reg_wr_data = 32'd9;
    reg_rd_en = 1'b1; reg_rd_addr = 12'h008;
    tick();
    reg_wr_en = 1'b0; reg_rd_en = 1'b0;
    check("rdwr_old", reg_rd_data, 32'd3);
    reg_read_check("rdwr_new", 12'h008, 32'd9);
    reg_write(12'h008, 32'd3);

    // T1: normal 3 ms run on ports 0 and 2
    reg_write(12'h000, 32'h0005_0001);
    check("t1_busy", {31'b0, busy}, 32'd1);
    wait_start();
    check("t1_start", {28'b0, start}, 32'h5);
    cnt = 0;
    do begin
      tick(); cnt++;
      if (cnt == 1) check("t1_start_width", {28'b0, start}, 32'h0);
    end while (stop == '0 && cnt < 4000);
    check("t1_stop", {28'b0, stop}, 32'h5);
    check("t1_stop_delay", cnt, 32'd3000);
    tick();
    check("t1_stop_width", {28'b0, stop}, 32'h0);
    wait_irq(20, cnt);
    check("t1_irq", {31'b0, irq}, 32'd1);
    check("t1_busy_done", {31'b0, busy}, 32'd0);
    reg_read_check("t1_status", 12'h004, 32'h0000_0702);
    reg_read_check("t1_elapsed", 12'h00C, 32'd3);
    for (int w = 0; w < 4; w++)
      reg_read_check($sformatf("t1_res_p0w%0d", w), 12'h400 + 12'(w*4), res_word(0, w, 32'h0));
    reg_read_check("t1_res_p2w0", 12'h420, res_word(2, 0, 32'h0));
    reg_read_check("t1_res_p2w3", 12'h42C, res_word(2, 3, 32'h0));
    reg_read_check("t1_res_p1w0_unmasked", 12'h410, 32'h0);

    // T2: generator 2 never ready -> ready timeout after 50 cycles
    gen_ready = 4'b1011;
    reg_write(12'h000, 32'h0005_0001);
    check("t2_busy", {31'b0, busy}, 32'd1);
    check("t2_irq_cleared", {31'b0, irq}, 32'd0);
    cnt = 0; saw_start = 1'b0;
    while (busy && cnt < 100) begin
      tick(); cnt++;
      if (start != '0) saw_start = 1'b1;
    end
    check("t2_timeout_cycles", cnt, 32'd50);
    check("t2_no_start", {31'b0, saw_start}, 32'd0);
    reg_read_check("t2_status", 12'h004, 32'h0000_0004);
    gen_ready = '1;

    // T3: abort 1500 cycles into a 5 ms run
    reg_write(12'h008, 32'd5);
    reg_write(12'h000, 32'h0005_0001);
    wait_start();
    check("t3_start", {28'b0, start}, 32'h5);
    repeat (1499) tick();
    reg_write(12'h000, 32'h0005_0002);
    check("t3_stop_next", {28'b0, stop}, 32'h5);
    wait_irq(20, cnt);
    check("t3_irq", {31'b0, irq}, 32'd1);
    reg_read_check("t3_status", 12'h004, 32'h0000_0712);
    reg_read_check("t3_elapsed", 12'h00C, 32'd1);

    // T4: checker 0 stuck after stop -> drain timeout, snapshot still taken
    set_results(32'h5555_0000);
    reg_write(12'h008, 32'd1);
    reg_write(12'h000, 32'h0005_0001);
    wait_start();
    wait_stop(2000, cnt);
    check("t4_stop", {28'b0, stop}, 32'h5);
    check_ready = 4'b1110;
    wait_irq(100, cnt);
    check("t4_drain_cycles", cnt, 32'd52);
    reg_read_check("t4_status", 12'h004, 32'h0000_070A);
    reg_read_check("t4_res_p0w0", 12'h400, res_word(0, 0, 32'h5555_0000));
    reg_read_check("t4_res_p2w1", 12'h424, res_word(2, 1, 32'h5555_0000));
    reg_read_check("t4_res_p1w0_unmasked", 12'h410, 32'h0);
    check_ready = '1;

    // T5: config and duration writes ignored while busy
    reg_write(12'h008, 32'd5);
    reg_write(12'h000, 32'h0002_0001);
    wait_start();
    check("t5_start", {28'b0, start}, 32'h2);
    reg_write(12'h140, 32'hCAFE_F00D);
    check("t5_cfg_busy_port", port_config[CW +: 32], 32'h0);
    reg_read_check("t5_cfg_busy_rd", 12'h140, 32'h0);
    reg_write(12'h008, 32'd9);
    reg_read_check("t5_dur_busy_rd", 12'h008, 32'd5);
    reg_write(12'h000, 32'h0000_0002);
    wait_irq(20, cnt);
    reg_read_check("t5_status_done", 12'h004, 32'h0000_0712);
    reg_write(12'h000, 32'h0000_0004);
    check("t5_irq_cleared", {31'b0, irq}, 32'd0);
    reg_read_check("t5_status_clr", 12'h004, 32'h0000_0010);
    reg_write(12'h140, 32'hCAFE_F00D);
    check("t5_cfg_idle_port", port_config[CW +: 32], 32'hCAFE_F00D);
    reg_read_check("t5_cfg_idle_rd", 12'h140, 32'hCAFE_F00D);
    reg_write(12'h000, 32'h0000_0001);
    check("t5_go_mask0", {31'b0, busy}, 32'd0);
    reg_write(12'h000, 32'h0005_0003);
    check("t5_go_abort", {31'b0, busy}, 32'd0);
    reg_read_check("t5_status_after", 12'h004, 32'h0000_0010);

    // zero duration: stop two cycles after start
    reg_write(12'h008, 32'd0);
    reg_write(12'h000, 32'h0005_0001);
    wait_start();
    check("d0_start", {28'b0, start}, 32'h5);
    wait_stop(20, cnt);
    check("d0_stop_delay", cnt, 32'd2);
    wait_irq(20, cnt);
    check("d0_irq", {31'b0, irq}, 32'd1);

    // T6: reset in the middle of a run
    reg_write(12'h008, 32'd5);
    reg_write(12'h000, 32'h0005_0001);
    wait_start();
    repeat (100) tick();
    check("t6_busy_pre", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    check("t6_start", {28'b0, start}, 32'h0);
    check("t6_stop", {28'b0, stop}, 32'h0);
    check("t6_busy", {31'b0, busy}, 32'd0);
    check("t6_irq", {31'b0, irq}, 32'd0);
    check("t6_cfg", {31'b0, |port_config}, 32'd0);
    rst = 1'b0;
    tick();
    reg_read_check("t6_status", 12'h004, 32'h0);
    reg_read_check("t6_cfg_p1", 12'h140, 32'h0);
    reg_read_check("t6_cfg_p0", 12'h100, 32'h0);
    reg_read_check("t6_dur", 12'h008, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
